// File: rtl/if_fetch_unit.sv
// IF-stage fetch engine: owns the PC, fetches over a gnt/rvalid handshake and writes the IF/ID side.
// Define FETCH_PERF_EN to add fetch/squash/stall performance counters.
module if_fetch_unit #(
   localparam int unsigned XLEN = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [XLEN-1:0] PC_INC   = 32'd4
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            stall_i,
   input  logic            jump_i,
   input  logic [XLEN-1:0] jump_addr_i,
   input  logic            branch_i,
   input  logic [XLEN-1:0] branch_addr_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   output logic [XLEN-1:0] addedPC_o,
   output logic [XLEN-1:0] inst_o,
   output logic            inst_valid_o,
   output logic [XLEN-1:0] pc_o
`ifdef FETCH_PERF_EN
   ,
   output logic [XLEN-1:0] perf_fetch_o,
   output logic [XLEN-1:0] perf_squash_o,
   output logic [XLEN-1:0] perf_stall_o
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_HOLD = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic              kill_q, kill_d;
   logic              req_q, req_d;
   logic [XLEN-1:0]   addr_q, addr_d;
   logic [XLEN-1:0]   added_q, added_d;
   logic [XLEN-1:0]   inst_q, inst_d;
   logic              valid_q, valid_d;

   logic              redirect;
   logic [XLEN-1:0]   target;
   logic [XLEN-1:0]   pc_inc;
   logic              resp_accept;
   logic              resp_kill;
   logic              flush_valid;

   // jump wins over branch when both request a redirect
   always_comb begin
      redirect = jump_i | branch_i;
      target   = jump_i ? jump_addr_i : branch_addr_i;
      pc_inc   = pc_q + PC_INC;
   end

   // next-state, PC and IF/ID payload
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      kill_d      = kill_q;
      added_d     = added_q;
      inst_d      = inst_q;
      valid_d     = valid_q;
      resp_accept = 1'b0;
      resp_kill   = 1'b0;
      flush_valid = 1'b0;

      if (valid_q && !stall_i) begin
         valid_d = 1'b0;
      end

      unique case (state_q)
         ST_IDLE: begin
            state_d = ST_REQ;
         end
         ST_REQ: begin
            if (imem_gnt_i) begin
               state_d = ST_WAIT;
               kill_d  = redirect;
            end
         end
         ST_WAIT: begin
            if (imem_rvalid_i) begin
               if (kill_q || redirect) begin
                  resp_kill = 1'b1;
                  kill_d    = 1'b0;
                  state_d   = ST_REQ;
               end else begin
                  resp_accept = 1'b1;
                  inst_d      = imem_rdata_i;
                  added_d     = pc_inc;
                  valid_d     = 1'b1;
                  pc_d        = pc_inc;
                  state_d     = stall_i ? ST_HOLD : ST_REQ;
               end
            end else if (redirect) begin
               kill_d = 1'b1;
            end
         end
         ST_HOLD: begin
            if (!stall_i) begin
               state_d = ST_REQ;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // redirect replaces the presented instruction with a NOP and overrides stall
      if (redirect) begin
         flush_valid = valid_q;
         pc_d        = target;
         added_d     = '0;
         inst_d      = '0;
         valid_d     = 1'b0;
         if (state_q == ST_HOLD) begin
            state_d = ST_REQ;
         end
      end

      req_d  = (state_d == ST_REQ);
      addr_d = pc_d;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         kill_q  <= 1'b0;
         req_q   <= 1'b0;
         addr_q  <= RESET_PC;
         added_q <= '0;
         inst_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         kill_q  <= kill_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         added_q <= added_d;
         inst_q  <= inst_d;
         valid_q <= valid_d;
      end
   end

   assign imem_req_o   = req_q;
   assign imem_addr_o  = addr_q;
   assign addedPC_o    = added_q;
   assign inst_o       = inst_q;
   assign inst_valid_o = valid_q;
   assign pc_o         = pc_q;

`ifdef FETCH_PERF_EN
   logic [XLEN-1:0] perf_fetch_q, perf_fetch_d;
   logic [XLEN-1:0] perf_squash_q, perf_squash_d;
   logic [XLEN-1:0] perf_stall_q, perf_stall_d;

   // a redirect can flush a live instruction and kill a response in one cycle
   always_comb begin
      perf_fetch_d  = perf_fetch_q + XLEN'(resp_accept);
      perf_squash_d = perf_squash_q + XLEN'(resp_kill) + XLEN'(flush_valid);
      perf_stall_d  = perf_stall_q + XLEN'(stall_i & valid_q);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         perf_fetch_q  <= '0;
         perf_squash_q <= '0;
         perf_stall_q  <= '0;
      end else begin
         perf_fetch_q  <= perf_fetch_d;
         perf_squash_q <= perf_squash_d;
         perf_stall_q  <= perf_stall_d;
      end
   end

   assign perf_fetch_o  = perf_fetch_q;
   assign perf_squash_o = perf_squash_q;
   assign perf_stall_o  = perf_stall_q;
`else
   logic unused_perf;
   assign unused_perf = resp_accept ^ resp_kill ^ flush_valid;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: scoreboard of expected captures, immediate-assertion checks.
module tb_if_fetch_unit;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        stall_i;
   logic        jump_i;
   logic [31:0] jump_addr_i;
   logic        branch_i;
   logic [31:0] branch_addr_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic [31:0] addedPC_o;
   logic [31:0] inst_o;
   logic        inst_valid_o;
   logic [31:0] pc_o;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] added;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   if_fetch_unit dut (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .stall_i       (stall_i),
      .jump_i        (jump_i),
      .jump_addr_i   (jump_addr_i),
      .branch_i      (branch_i),
      .branch_addr_i (branch_addr_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .addedPC_o     (addedPC_o),
      .inst_o        (inst_o),
      .inst_valid_o  (inst_valid_o),
      .pc_o          (pc_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One fetch from REQ: grant immediately, respond one cycle later
   task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data, input logic stall_resp);
      exp_t e;
      chk("req_before_gnt", 32'(imem_req_o), 32'd1);
      chk("addr_before_gnt", imem_addr_o, addr);
      imem_gnt_i = 1'b1;
      sb.push_back('{inst: data, added: addr + 32'd4});
      tick();
      imem_gnt_i = 1'b0;
      chk("req_in_wait", 32'(imem_req_o), 32'd0);
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = data;
      stall_i       = stall_resp;
      tick();
      imem_rvalid_i = 1'b0;
      if (sb.size() == 0) begin
         chk("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
         e = sb.pop_front();
         chk("cap_inst", inst_o, e.inst);
         chk("cap_added", addedPC_o, e.added);
         chk("cap_valid", 32'(inst_valid_o), 32'd1);
         chk("cap_pc", pc_o, e.added);
         chk("req_after_cap", 32'(imem_req_o), 32'(!stall_resp));
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req"}, 32'(imem_req_o), 32'd0);
      chk({tag, "_addr"}, imem_addr_o, 32'h0);
      chk({tag, "_pc"}, pc_o, 32'h0);
      chk({tag, "_added"}, addedPC_o, 32'h0);
      chk({tag, "_inst"}, inst_o, 32'h0);
      chk({tag, "_valid"}, 32'(inst_valid_o), 32'd0);
   endtask

   initial begin
      rst_n_i       = 1'b0;
      stall_i       = 1'b0;
      jump_i        = 1'b0;
      jump_addr_i   = 32'h0;
      branch_i      = 1'b0;
      branch_addr_i = 32'h0;
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'h0;

      // reset values, then one IDLE cycle before the first request
      tick();
      tick();
      chk_reset_vals("rst");
      rst_n_i = 1'b1;
      tick();

      // straight-line fetch 0,4,8 with the 4 fetch stalled into HOLD
      do_fetch(32'h0, 32'h2002_0005, 1'b0);
      do_fetch(32'h4, 32'h1111_0004, 1'b1);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("hold_req", 32'(imem_req_o), 32'd0);
         chk("hold_inst", inst_o, 32'h1111_0004);
         chk("hold_added", addedPC_o, 32'h8);
         chk("hold_valid", 32'(inst_valid_o), 32'd1);
      end
      stall_i = 1'b0;
      tick();
      chk("unhold_valid", 32'(inst_valid_o), 32'd0);
      chk("unhold_inst_kept", inst_o, 32'h1111_0004);
      chk("unhold_added_kept", addedPC_o, 32'h8);
      do_fetch(32'h8, 32'h2222_0008, 1'b0);

      // jump while WAIT: outstanding response squashed
      imem_gnt_i = 1'b1;
      tick();
      imem_gnt_i  = 1'b0;
      jump_i      = 1'b1;
      jump_addr_i = 32'h0000_0100;
      tick();
      jump_i = 1'b0;
      chk("jmp_inst", inst_o, 32'h0);
      chk("jmp_added", addedPC_o, 32'h0);
      chk("jmp_valid", 32'(inst_valid_o), 32'd0);
      chk("jmp_pc", pc_o, 32'h100);
      chk("jmp_req", 32'(imem_req_o), 32'd0);
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = 32'hDEAD_BEEF;
      tick();
      imem_rvalid_i = 1'b0;
      chk("jmp_squash_valid", 32'(inst_valid_o), 32'd0);
      chk("jmp_squash_inst", inst_o, 32'h0);
      do_fetch(32'h100, 32'h3333_0100, 1'b0);

      // jump and branch together in REQ: jump target wins
      jump_i        = 1'b1;
      jump_addr_i   = 32'h40;
      branch_i      = 1'b1;
      branch_addr_i = 32'h80;
      tick();
      jump_i   = 1'b0;
      branch_i = 1'b0;
      chk("prio_flush_valid", 32'(inst_valid_o), 32'd0);
      chk("prio_flush_inst", inst_o, 32'h0);
      do_fetch(32'h40, 32'h4444_0040, 1'b0);

      // redirect coincident with grant
      imem_gnt_i    = 1'b1;
      branch_i      = 1'b1;
      branch_addr_i = 32'h200;
      tick();
      imem_gnt_i = 1'b0;
      branch_i   = 1'b0;
      chk("gntred_req", 32'(imem_req_o), 32'd0);
      chk("gntred_pc", pc_o, 32'h200);
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = 32'hBAD0_0044;
      tick();
      imem_rvalid_i = 1'b0;
      chk("gntred_valid", 32'(inst_valid_o), 32'd0);
      chk("gntred_inst", inst_o, 32'h0);
      do_fetch(32'h200, 32'h5555_0200, 1'b0);

      // PC wraps past the top of the address space
      jump_i      = 1'b1;
      jump_addr_i = 32'hFFFF_FFFC;
      tick();
      jump_i = 1'b0;
      do_fetch(32'hFFFF_FFFC, 32'h6666_FFFC, 1'b0);
      do_fetch(32'h0, 32'h7777_0000, 1'b0);

      // asynchronous reset in WAIT; late response must be ignored
      imem_gnt_i = 1'b1;
      tick();
      imem_gnt_i = 1'b0;
      rst_n_i    = 1'b0;
      #1;
      chk_reset_vals("midrst");
      tick();
      rst_n_i       = 1'b1;
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = 32'hBAD0_0004;
      tick();
      imem_rvalid_i = 1'b0;
      chk("postrst_valid", 32'(inst_valid_o), 32'd0);
      chk("postrst_inst", inst_o, 32'h0);
      chk("postrst_pc", pc_o, 32'h0);
      do_fetch(32'h0, 32'h8888_0000, 1'b0);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- IF-stage fetch engine; the writer side of the IF/ID pipeline register.
- Owns the PC and issues instruction-memory requests over a grant/response handshake.
- Presents addedPC (PC+4) and the instruction to IF/ID, and honours the hazard stall and jump/branch redirect signals that IF/ID also receives.
- One outstanding fetch at a time; stale responses after a redirect are squashed.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_INC, 32'd4, PC increment per instruction

Ports:
clk_i  input  1  clock, all state updates on posedge
rst_n_i  input  1  asynchronous active-low reset
stall_i  input  1  hazard stall; IF/ID is not accepting
jump_i  input  1  jump redirect request
jump_addr_i  input  32  jump target
branch_i  input  1  taken-branch redirect request
branch_addr_i  input  32  branch target
imem_req_o  output  1  fetch request valid
imem_addr_o  output  32  fetch address
imem_gnt_i  input  1  request accepted this cycle
imem_rvalid_i  input  1  response data valid
imem_rdata_i  input  32  response instruction
addedPC_o  output  32  PC+PC_INC of presented instruction
inst_o  output  32  presented instruction
inst_valid_o  output  1  addedPC_o/inst_o hold a live instruction
pc_o  output  32  current fetch PC

Behaviour:
- Reset: rst_n_i is asynchronous active-low; clk_i is the only clock.
  - Reset values: state=IDLE, pc=RESET_PC, imem_req_o=0, imem_addr_o=RESET_PC, addedPC_o=0, inst_o=0, inst_valid_o=0, kill=0.
  - Reset mid-fetch abandons the transaction. Any imem_rvalid_i arriving outside WAIT is ignored.
- FSM states IDLE, REQ, WAIT, HOLD:
  - IDLE: one cycle after reset release, then REQ.
  - REQ: imem_req_o=1, imem_addr_o=pc. imem_gnt_i=1 -> WAIT. Address stays stable until granted, except on redirect.
  - WAIT: imem_req_o=0. On imem_rvalid_i=1 with kill=0:
    - inst_o<=imem_rdata_i, addedPC_o<=pc+PC_INC, inst_valid_o<=1, pc<=pc+PC_INC.
    - Next state is REQ if stall_i=0, else HOLD.
    - imem_rvalid_i is never expected in the grant cycle.
  - HOLD: outputs frozen. stall_i=0 -> REQ.
- Consumption:
  - An instruction is consumed when inst_valid_o=1 and stall_i=0 at a posedge.
  - If consumed and no new response is captured that cycle, inst_valid_o<=0. addedPC_o and inst_o keep their values.
  - While stall_i=1 all outputs hold, including a valid instruction.
- Redirect (jump_i | branch_i):
  - jump_i has priority over branch_i. Redirect overrides stall_i.
  - Same posedge: pc<=target, addedPC_o<=0, inst_o<=0 (NOP), inst_valid_o<=0.
  - In REQ without grant: stay REQ; new address appears next cycle.
  - In REQ with simultaneous imem_gnt_i: -> WAIT with kill=1.
  - In WAIT: kill<=1, stay WAIT. A killed response is discarded, kill<=0, -> REQ at the new pc.
  - A response arriving in the same cycle as a redirect is discarded.
  - In HOLD: -> REQ at the target.
- Arithmetic: pc+PC_INC is 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0.

Optional Feature:
FETCH_PERF_EN:
- Defined: adds outputs perf_fetch_o[31:0] (responses accepted), perf_squash_o[31:0] (killed responses plus flushed valid instructions) and perf_stall_o[31:0] (cycles with stall_i=1 and inst_valid_o=1).
  - All counters reset to 0 and wrap silently.
- Undefined: these ports and counters are absent; remaining behaviour is identical.

Test Plan:
- Reset, memory grants immediately, rvalid 1 cycle later, rdata=32'h2002_0005, stall_i=0 -> imem_addr_o sequence 0,4,8; first capture inst_o=32'h2002_0005, addedPC_o=4, inst_valid_o=1.
- stall_i=1 for 3 cycles while inst_valid_o=1 -> state HOLD, outputs frozen, imem_req_o=0; after stall release the next request is at addr 8.
- jump_i=1, jump_addr_i=32'h0000_0100 during WAIT -> inst_o=0, addedPC_o=0, inst_valid_o=0; pending response discarded; next imem_addr_o=32'h100.
- jump_i=1 (target 32'h40) and branch_i=1 (target 32'h80) in the same cycle -> next fetch at 32'h40.
- Redirect in the same cycle as imem_gnt_i -> that response is ignored; the following request goes to the target.
- rst_n_i pulsed low mid-WAIT, rvalid arriving after release -> outputs at reset values, response ignored, fetch restarts at RESET_PC.
